// File: rtl/gap_pkg.sv
// Shared types and constants for the gap pulse generator.
package gap_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOn   = 2'd1,
    StOff  = 2'd2
  } gap_state_e;

  typedef logic [15:0] off_time_t;

  localparam int unsigned RatioClamp = 100;

  function automatic logic [31:0] clamp_ratio(input logic [31:0] r);
    return (r > 32'(RatioClamp)) ? 32'(RatioClamp) : r;
  endfunction

endpackage

// File: rtl/gap_pulse_gen_if.sv
// Control and status bundle between the gap-state classifier side and the pulse generator.
interface gap_pulse_gen_if;
  import gap_pkg::*;

  logic        en;
  logic [31:0] ratio;
  logic        ratio_valid;
  logic        pulse_out;
  logic        pulse_start;
  off_time_t   t_off_cur;
  logic [31:0] pulse_cnt;

  modport master (
    output en, ratio, ratio_valid,
    input  pulse_out, pulse_start, t_off_cur, pulse_cnt
  );

  modport slave (
    input  en, ratio, ratio_valid,
    output pulse_out, pulse_start, t_off_cur, pulse_cnt
  );

endinterface

// File: rtl/off_time_adapter.sv
// Pending off-time register, stepped up or down by the short+arc ratio with
// saturation at the configured bounds.
module off_time_adapter
  import gap_pkg::*;
#(
  parameter int unsigned T_OFF_INIT = 100,
  parameter int unsigned T_OFF_MIN  = 20,
  parameter int unsigned T_OFF_MAX  = 400,
  parameter int unsigned T_STEP     = 10,
  parameter int unsigned HI_TH      = 40,
  parameter int unsigned LO_TH      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ratio_valid_i,
  input  logic [31:0] ratio_i,
  output off_time_t   t_off_next_o
);

  off_time_t   t_off_next_d, t_off_next_q;
  logic [31:0] ratio_c;
  logic [16:0] inc, dec;

  // 17-bit sums so neither bound can wrap before the saturation compare.
  always_comb begin
    ratio_c      = clamp_ratio(ratio_i);
    inc          = {1'b0, t_off_next_q} + 17'(T_STEP);
    dec          = {1'b0, t_off_next_q} - 17'(T_STEP);
    t_off_next_d = t_off_next_q;
    if (ratio_valid_i) begin
      if (ratio_c > 32'(HI_TH)) begin
        t_off_next_d = (inc > 17'(T_OFF_MAX)) ? 16'(T_OFF_MAX) : inc[15:0];
      end else if (ratio_c < 32'(LO_TH)) begin
        t_off_next_d = (dec[16] || (dec < 17'(T_OFF_MIN))) ? 16'(T_OFF_MIN) : dec[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_off_next_q <= 16'(T_OFF_INIT);
    end else begin
      t_off_next_q <= t_off_next_d;
    end
  end

  assign t_off_next_o = t_off_next_q;

endmodule

// File: rtl/gap_pulse_gen.sv
// Discharge pulse train: fixed on-time, adaptive off-time taken from the
// adapter at the start of each OFF phase.
module gap_pulse_gen
  import gap_pkg::*;
#(
  parameter int unsigned T_ON       = 50,
  parameter int unsigned T_OFF_INIT = 100,
  parameter int unsigned T_OFF_MIN  = 20,
  parameter int unsigned T_OFF_MAX  = 400,
  parameter int unsigned T_STEP     = 10,
  parameter int unsigned HI_TH      = 40,
  parameter int unsigned LO_TH      = 10
) (
  input logic            clk,
  input logic            rst,
  gap_pulse_gen_if.slave bus
);

  gap_state_e  state_d, state_q;
  off_time_t   cnt_d, cnt_q;
  off_time_t   t_off_cur_d, t_off_cur_q;
  off_time_t   t_off_next;
  logic        pulse_out_d, pulse_out_q;
  logic        pulse_start_d, pulse_start_q;
  logic [31:0] pulse_cnt_d, pulse_cnt_q;

  off_time_adapter #(
    .T_OFF_INIT (T_OFF_INIT),
    .T_OFF_MIN  (T_OFF_MIN),
    .T_OFF_MAX  (T_OFF_MAX),
    .T_STEP     (T_STEP),
    .HI_TH      (HI_TH),
    .LO_TH      (LO_TH)
  ) u_adapter (
    .clk           (clk),
    .rst           (rst),
    .ratio_valid_i (bus.ratio_valid),
    .ratio_i       (bus.ratio),
    .t_off_next_o  (t_off_next)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    t_off_cur_d   = t_off_cur_q;
    pulse_cnt_d   = pulse_cnt_q;
    pulse_start_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.en) begin
          state_d = StOn;
          cnt_d   = '0;
        end
      end
      StOn: begin
        // Dropping en aborts the pulse but the full off-time still follows.
        if (!bus.en || (cnt_q == 16'(T_ON - 1))) begin
          state_d     = StOff;
          cnt_d       = '0;
          t_off_cur_d = t_off_next;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StOff: begin
        if (cnt_q == (t_off_cur_q - 16'd1)) begin
          state_d = bus.en ? StOn : StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    if ((state_d == StOn) && (state_q != StOn)) begin
      pulse_start_d = 1'b1;
      pulse_cnt_d   = pulse_cnt_q + 32'd1;
    end
    pulse_out_d = (state_d == StOn);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      t_off_cur_q   <= 16'(T_OFF_INIT);
      pulse_out_q   <= 1'b0;
      pulse_start_q <= 1'b0;
      pulse_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      t_off_cur_q   <= t_off_cur_d;
      pulse_out_q   <= pulse_out_d;
      pulse_start_q <= pulse_start_d;
      pulse_cnt_q   <= pulse_cnt_d;
    end
  end

  assign bus.pulse_out   = pulse_out_q;
  assign bus.pulse_start = pulse_start_q;
  assign bus.t_off_cur   = t_off_cur_q;
  assign bus.pulse_cnt   = pulse_cnt_q;

endmodule

// File: tb/tb_gap_pulse_gen.sv
// Directed bench for gap_pulse_gen at default parameters.
module tb_gap_pulse_gen;
  import gap_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  gap_pulse_gen_if bus_if ();

  gap_pulse_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [31:0] r);
    bus_if.ratio       = r;
    bus_if.ratio_valid = 1'b1;
    tick();
    bus_if.ratio_valid = 1'b0;
  endtask

  // Counts sampled cycles at the given level; the bound turns a stuck output into a failure.
  task automatic measure(input logic lvl, output int n);
    n = 0;
    while ((bus_if.pulse_out === lvl) && (n < 2000)) begin
      n++;
      tick();
    end
  endtask

  logic [31:0] tbl_ratio [7] = '{32'd40, 32'd10, 32'd41, 32'd9, 32'd101, 32'hFFFF_FFFF, 32'd0};
  logic [31:0] tbl_next  [7] = '{32'd100, 32'd100, 32'd110, 32'd100, 32'd110, 32'd120, 32'd110};

  initial begin
    int n;
    int starts;
    int highs;
    rst                = 1'b1;
    bus_if.en          = 1'b0;
    bus_if.ratio       = '0;
    bus_if.ratio_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    check_eq("rst_pulse_out", 32'(bus_if.pulse_out), 32'd0);
    check_eq("rst_pulse_start", 32'(bus_if.pulse_start), 32'd0);
    check_eq("rst_pulse_cnt", bus_if.pulse_cnt, 32'd0);
    check_eq("rst_t_off_cur", 32'(bus_if.t_off_cur), 32'd100);
    check_eq("rst_t_off_next", 32'(dut.u_adapter.t_off_next_q), 32'd100);
    check_eq("rst_state", 32'(dut.state_q), 32'(StIdle));

    // Threshold and clamp boundaries, accepted while idle.
    for (int i = 0; i < 7; i++) begin
      strobe(tbl_ratio[i]);
      check_eq($sformatf("thr_%0d", i), 32'(dut.u_adapter.t_off_next_q), tbl_next[i]);
    end
    check_eq("idle_t_off_cur", 32'(bus_if.t_off_cur), 32'd100);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Free-running train at default timing.
    bus_if.en = 1'b1;
    tick();
    for (int p = 1; p <= 3; p++) begin
      check_eq($sformatf("per%0d_start", p), 32'(bus_if.pulse_start), 32'd1);
      check_eq($sformatf("per%0d_cnt", p), bus_if.pulse_cnt, 32'(p));
      measure(1'b1, n);
      check_eq($sformatf("per%0d_on", p), 32'(n), 32'd50);
      check_eq($sformatf("per%0d_start_low", p), 32'(bus_if.pulse_start), 32'd0);
      measure(1'b0, n);
      check_eq($sformatf("per%0d_off", p), 32'(n), 32'd100);
    end

    // Three high-ratio strobes inside an OFF phase.
    measure(1'b1, n);
    check_eq("r75_cur_before", 32'(bus_if.t_off_cur), 32'd100);
    repeat (3) strobe(32'd75);
    measure(1'b0, n);
    check_eq("r75_off_rest", 32'(n), 32'd97);
    measure(1'b1, n);
    check_eq("r75_t_off_cur", 32'(bus_if.t_off_cur), 32'd130);
    measure(1'b0, n);
    check_eq("r75_off_len", 32'(n), 32'd130);

    // Strobe on the exact ON->OFF edge.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst_overrides_en", 32'(bus_if.pulse_out), 32'd0);
    tick();
    check_eq("edge_on", 32'(bus_if.pulse_out), 32'd1);
    check_eq("edge_cnt", bus_if.pulse_cnt, 32'd1);
    repeat (49) tick();
    check_eq("edge_last_on", 32'(bus_if.pulse_out), 32'd1);
    bus_if.ratio       = 32'd50;
    bus_if.ratio_valid = 1'b1;
    tick();
    bus_if.ratio_valid = 1'b0;
    check_eq("edge_off", 32'(bus_if.pulse_out), 32'd0);
    check_eq("edge_t_off_cur", 32'(bus_if.t_off_cur), 32'd100);
    measure(1'b0, n);
    check_eq("edge_off_len", 32'(n), 32'd100);
    measure(1'b1, n);
    check_eq("edge_next_cur", 32'(bus_if.t_off_cur), 32'd110);
    measure(1'b0, n);
    check_eq("edge_next_len", 32'(n), 32'd110);

    // en dropped on cycle 10 of ON.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    repeat (9) tick();
    bus_if.en = 1'b0;
    tick();
    check_eq("abort_pulse_out", 32'(bus_if.pulse_out), 32'd0);
    check_eq("abort_state_off", 32'(dut.state_q), 32'(StOff));
    repeat (99) tick();
    check_eq("abort_off_last", 32'(dut.state_q), 32'(StOff));
    tick();
    check_eq("abort_idle", 32'(dut.state_q), 32'(StIdle));
    starts = 0;
    highs  = 0;
    repeat (200) begin
      tick();
      if (bus_if.pulse_start === 1'b1) starts++;
      if (bus_if.pulse_out === 1'b1) highs++;
    end
    check_eq("abort_no_start", 32'(starts), 32'd0);
    check_eq("abort_no_pulse", 32'(highs), 32'd0);
    check_eq("abort_cnt", bus_if.pulse_cnt, 32'd1);

    // Saturation at both bounds.
    repeat (40) strobe(32'd0);
    check_eq("sat_min_next", 32'(dut.u_adapter.t_off_next_q), 32'd20);
    bus_if.en = 1'b1;
    tick();
    measure(1'b1, n);
    check_eq("sat_min_cur", 32'(bus_if.t_off_cur), 32'd20);
    measure(1'b0, n);
    check_eq("sat_min_len", 32'(n), 32'd20);
    bus_if.en = 1'b0;
    repeat (31) tick();
    repeat (40) strobe(32'd500);
    check_eq("sat_max_next", 32'(dut.u_adapter.t_off_next_q), 32'd400);
    check_eq("sat_max_cur_hold", 32'(bus_if.t_off_cur), 32'd20);
    bus_if.en = 1'b1;
    tick();
    measure(1'b1, n);
    check_eq("sat_max_cur", 32'(bus_if.t_off_cur), 32'd400);
    measure(1'b0, n);
    check_eq("sat_max_len", 32'(n), 32'd400);

    // Reset in the middle of ON.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_if.en = 1'b0;
    repeat (15) strobe(32'd75);
    check_eq("pre_rst_next", 32'(dut.u_adapter.t_off_next_q), 32'd250);
    bus_if.en = 1'b1;
    tick();
    repeat (5) tick();
    check_eq("pre_rst_on", 32'(bus_if.pulse_out), 32'd1);
    rst = 1'b1;
    tick();
    check_eq("midrst_pulse_out", 32'(bus_if.pulse_out), 32'd0);
    check_eq("midrst_cnt", bus_if.pulse_cnt, 32'd0);
    check_eq("midrst_t_off_cur", 32'(bus_if.t_off_cur), 32'd100);
    check_eq("midrst_t_off_next", 32'(dut.u_adapter.t_off_next_q), 32'd100);
    rst       = 1'b0;
    bus_if.en = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
